// File: rtl/spi_pkg.sv
// ---------------------------------------------------------------------------
// spi_pkg
//   Shared types and constants for the SPI transmit arbiter family.
//   - arb_state_t : arbiter FSM encoding (2 bits)
//   - SPI_DW      : default SPI word width
//   - SPI_TIMEOUT : default watchdog limit in clk cycles
//   - wd_width()  : counter width needed to hold 0..timeout-1
// ---------------------------------------------------------------------------
package spi_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LAUNCH  = 2'd1,
      SHIFT   = 2'd2,
      RELEASE = 2'd3
   } arb_state_t;

   localparam int SPI_DW      = 12;
   localparam int SPI_TIMEOUT = 4096;

   function automatic int wd_width(input int timeout);
      return (timeout > 1) ? $clog2(timeout) : 1;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
//   Combinational rotate-priority encoder. Searches req starting at ptr,
//   wrapping modulo N; the first set bit at or after ptr wins.
//   Ports:
//     req   in  N   request vector
//     ptr   in  PW  search start index (must be < N)
//     valid out 1   any request present
//     idx   out PW  winning index (0 when !valid)
// ---------------------------------------------------------------------------
module rr_pick #(
   parameter int N  = 4,
   parameter int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic          valid,
   output logic [PW-1:0] idx
);

   // Walk offsets from farthest to nearest so the nearest hit is written last.
   always_comb begin
      logic [PW:0]   sum;
      logic [PW-1:0] c;
      valid = 1'b0;
      idx   = '0;
      sum   = '0;
      c     = '0;
      for (int k = N - 1; k >= 0; k--) begin
         sum = {1'b0, ptr} + (PW+1)'(k);
         if (sum >= (PW+1)'(N))
            sum = sum - (PW+1)'(N);
         c = sum[PW-1:0];
         if (req[c]) begin
            valid = 1'b1;
            idx   = c;
         end
      end
   end

endmodule

// File: rtl/spi_tx_arbiter.sv
// ---------------------------------------------------------------------------
// spi_tx_arbiter
//   Round-robin arbiter sharing one DW-bit SPI transmit engine among NREQ
//   requesters. Latches the winner's word, starts the engine, waits for the
//   engine's slow-domain done, then acks (or errs on watchdog expiry).
//   Ports:
//     clk, rst_n  system clock, synchronous active-low reset
//     req         level request per requester, held until ack/err
//     req_data    word i at [i*DW +: DW]
//     gnt         one-hot current owner
//     ack / err   one-cycle completion / timeout pulse to owner
//     busy        FSM not in IDLE
//     ss_n        per-slave select; owner's line follows eng_cs
//     eng_start   start level to engine
//     eng_din     latched word to engine
//     eng_cs      engine chip-select (low = shifting), async to clk
//     eng_done    engine done pulse, async to clk, many clk wide
// ---------------------------------------------------------------------------
module spi_tx_arbiter
   import spi_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int DW      = SPI_DW,
   parameter int TIMEOUT = SPI_TIMEOUT
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ*DW-1:0] req_data,
   output logic [NREQ-1:0]    gnt,
   output logic [NREQ-1:0]    ack,
   output logic [NREQ-1:0]    err,
   output logic               busy,
   output logic [NREQ-1:0]    ss_n,
   output logic               eng_start,
   output logic [DW-1:0]      eng_din,
   input  logic               eng_cs,
   input  logic               eng_done
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int WW = wd_width(TIMEOUT);
   localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT - 1);
   localparam logic [PW-1:0] LAST_IDX = PW'(NREQ - 1);

   arb_state_t    state;
   logic [PW-1:0] owner;
   logic [PW-1:0] ptr;
   logic [WW-1:0] wd;

   // Synchronizer state. cs resets low ("engine busy") so that after a reset
   // the arbiter only grants once it has really seen the engine go idle.
   logic cs_s1, cs_s2;
   logic done_s1, done_s2, done_d;
   logic done_rise;

   logic          pick_valid;
   logic [PW-1:0] pick_idx;
   logic [DW-1:0] pick_word;

   assign done_rise = done_s2 & ~done_d;

   rr_pick #(.N(NREQ), .PW(PW)) u_pick (
      .req   (req),
      .ptr   (ptr),
      .valid (pick_valid),
      .idx   (pick_idx)
   );

   always_comb begin
      pick_word = req_data[DW-1:0];
      for (int i = 0; i < NREQ; i++)
         if (pick_idx == PW'(i))
            pick_word = req_data[i*DW +: DW];
   end

   // Chip-select is routed straight through so the slave sees the engine's
   // edges without synchronizer delay.
   always_comb begin
      ss_n = '1;
      for (int i = 0; i < NREQ; i++)
         if (gnt[i])
            ss_n[i] = eng_cs;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cs_s1     <= 1'b0;
         cs_s2     <= 1'b0;
         done_s1   <= 1'b0;
         done_s2   <= 1'b0;
         done_d    <= 1'b0;
         state     <= IDLE;
         owner     <= '0;
         ptr       <= '0;
         wd        <= '0;
         gnt       <= '0;
         ack       <= '0;
         err       <= '0;
         busy      <= 1'b0;
         eng_start <= 1'b0;
         eng_din   <= '0;
      end else begin
         cs_s1   <= eng_cs;
         cs_s2   <= cs_s1;
         done_s1 <= eng_done;
         done_s2 <= done_s1;
         done_d  <= done_s2;
         ack     <= '0;
         err     <= '0;

         case (state)
            IDLE: begin
               if (pick_valid && cs_s2) begin
                  owner     <= pick_idx;
                  eng_din   <= pick_word;
                  gnt       <= NREQ'(1) << pick_idx;
                  busy      <= 1'b1;
                  eng_start <= 1'b1;
                  wd        <= '0;
                  state     <= LAUNCH;
               end
            end

            LAUNCH: begin
               if (!cs_s2) begin
                  eng_start <= 1'b0;
                  wd        <= '0;
                  state     <= SHIFT;
               end else if (wd == WD_LAST) begin
                  eng_start <= 1'b0;
                  err       <= gnt;
                  wd        <= '0;
                  state     <= RELEASE;
               end else begin
                  wd <= wd + 1'b1;
               end
            end

            // A done edge beats a same-cycle timeout: the transfer did finish.
            SHIFT: begin
               if (done_rise) begin
                  ack   <= gnt;
                  wd    <= '0;
                  state <= RELEASE;
               end else if (wd == WD_LAST) begin
                  err   <= gnt;
                  wd    <= '0;
                  state <= RELEASE;
               end else begin
                  wd <= wd + 1'b1;
               end
            end

            // Hold ownership until the engine is fully quiet, so the next
            // transfer can never see this transfer's done.
            RELEASE: begin
               if (!done_s2 && cs_s2) begin
                  gnt   <= '0;
                  busy  <= 1'b0;
                  ptr   <= (owner == LAST_IDX) ? '0 : owner + 1'b1;
                  state <= IDLE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_tx_arbiter.sv
module tb_spi_tx_arbiter;

   localparam int NREQ    = 4;
   localparam int DW      = 12;
   localparam int TIMEOUT = 64;

   logic               clk      = 1'b0;
   logic               rst_n    = 1'b0;
   logic [NREQ-1:0]    req      = '0;
   logic [NREQ*DW-1:0] req_data = '0;
   logic [NREQ-1:0]    gnt, ack, err, ss_n;
   logic               busy, eng_start;
   logic [DW-1:0]      eng_din;
   logic               eng_cs   = 1'b1;
   logic               eng_done = 1'b0;
   logic               hang     = 1'b0;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   spi_tx_arbiter #(.NREQ(NREQ), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .req_data  (req_data),
      .gnt       (gnt),
      .ack       (ack),
      .err       (err),
      .busy      (busy),
      .ss_n      (ss_n),
      .eng_start (eng_start),
      .eng_din   (eng_din),
      .eng_cs    (eng_cs),
      .eng_done  (eng_done)
   );

   // Engine model: start -> 2 cycles -> cs low for 10 cycles -> cs high with
   // done high for 6 cycles -> idle. Ignores reset; hang ignores start.
   int m_st  = 0;
   int m_cnt = 0;
   always @(posedge clk) begin
      case (m_st)
         0: begin
            eng_cs   <= 1'b1;
            eng_done <= 1'b0;
            if (eng_start && !hang) begin m_st <= 1; m_cnt <= 0; end
         end
         1: if (m_cnt == 1) begin eng_cs <= 1'b0; m_st <= 2; m_cnt <= 0; end
            else m_cnt <= m_cnt + 1;
         2: if (m_cnt == 9) begin eng_cs <= 1'b1; eng_done <= 1'b1; m_st <= 3; m_cnt <= 0; end
            else m_cnt <= m_cnt + 1;
         default: if (m_cnt == 5) begin eng_done <= 1'b0; m_st <= 0; end
            else m_cnt <= m_cnt + 1;
      endcase
   end

   // Monitor: grant log, per-requester pulse counts, protocol violations.
   logic [NREQ-1:0] prev_gnt = '0;
   logic [NREQ-1:0] prev_ack = '0;
   int              gq[$];
   logic [DW-1:0]   dq[$];
   int              ack_cnt[NREQ] = '{default: 0};
   int              err_cnt[NREQ] = '{default: 0};
   int              overlap  = 0;
   int              both     = 0;
   int              long_ack = 0;

   function automatic int oh2i(input logic [NREQ-1:0] v);
      for (int i = 0; i < NREQ; i++)
         if (v[i]) return i;
      return -1;
   endfunction

   always @(negedge clk) begin
      if (gnt != '0 && prev_gnt == '0) begin
         gq.push_back(oh2i(gnt));
         dq.push_back(eng_din);
      end
      if ($countones(gnt) > 1 || (gnt != '0 && prev_gnt != '0 && gnt != prev_gnt))
         overlap++;
      for (int i = 0; i < NREQ; i++) begin
         if (ack[i]) ack_cnt[i]++;
         if (err[i]) err_cnt[i]++;
      end
      if ((ack & err) != '0) both++;
      if ((ack & prev_ack) != '0) long_ack++;
      prev_gnt = gnt;
      prev_ack = ack;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_gnt();
      int t = 0;
      while (gnt == '0 && t < 20) begin @(negedge clk); t++; end
      chk("gnt_wait", 32'(t < 20), 1);
   endtask

   task automatic wait_cs_low();
      int t = 0;
      while (eng_cs !== 1'b0 && t < 100) begin @(negedge clk); t++; end
      chk("cs_low_wait", 32'(t < 100), 1);
   endtask

   // Waits for target ack/err pulses; optionally drops each served request.
   task automatic wait_resp(input int target, input logic drop);
      int n = 0;
      int t = 0;
      while (n < target && t < 2000) begin
         @(negedge clk);
         t++;
         for (int i = 0; i < NREQ; i++)
            if (ack[i] || err[i]) begin
               n++;
               if (drop) req[i] = 1'b0;
            end
      end
      chk("resp_wait", 32'(n >= target), 1);
   endtask

   task automatic wait_idle();
      int t = 0;
      while (busy !== 1'b0 && t < 200) begin @(negedge clk); t++; end
      chk("idle_wait", 32'(t < 200), 1);
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, "_gnt"},   gnt,       0);
      chk({tag, "_ackerr"}, {ack, err}, 0);
      chk({tag, "_busy"},  busy,      0);
      chk({tag, "_start"}, eng_start, 0);
      chk({tag, "_din"},   eng_din,   0);
      chk({tag, "_ssn"},   ss_n,      4'hF);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "bench timeout");
   end

   initial begin
      int a0, a1, a2, e1, base, cycles, viol, t;

      // ---- reset state ----
      cyc(3);
      chk_reset_outs("rst");
      rst_n = 1'b1;
      cyc(4);

      // ---- T1: single request ----
      req_data[0 +: DW] = 12'hA5C;
      req = 4'b0001;
      cyc(1);
      chk("t1_gnt",   gnt,       4'b0001);
      chk("t1_din",   eng_din,   12'hA5C);
      chk("t1_start", eng_start, 1);
      chk("t1_busy",  busy,      1);
      wait_cs_low();
      chk("t1_start_at_cs", eng_start, 1);
      cyc(4);
      chk("t1_start_drop", eng_start, 0);
      chk("t1_ssn",        ss_n,      4'b1110);
      a0 = ack_cnt[0];
      wait_resp(1, 1);
      wait_idle();
      chk("t1_rel_gnt",  gnt, 0);
      chk("t1_rel_eng",  {eng_cs, eng_done}, 2'b10);
      cyc(2);
      chk("t1_ack_cnt",  ack_cnt[0] - a0, 1);
      chk("t1_err_cnt",  err_cnt[0], 0);

      // ---- T2: all four, ptr=0 after reset ----
      @(negedge clk); rst_n = 1'b0; cyc(1); rst_n = 1'b1; cyc(4);
      req_data = {12'h004, 12'h003, 12'h002, 12'h001};
      base = gq.size();
      req = 4'b1111;
      wait_resp(4, 1);
      wait_idle();
      cyc(2);
      chk("t2_ngrants", gq.size() - base, 4);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("t2_order%0d", k), gq[base + k], k);
         chk($sformatf("t2_din%0d", k),   dq[base + k], k + 1);
      end
      chk("t2_acks", {8'(ack_cnt[3]), 8'(ack_cnt[2]), 8'(ack_cnt[1]), 8'(ack_cnt[0])},
          {8'd1, 8'd1, 8'd1, 8'd2});
      chk("t2_overlap", overlap, 0);

      // ---- T3: fairness, req=1001 held ----
      base = gq.size();
      req = 4'b1001;
      wait_resp(4, 0);
      req = '0;
      wait_idle();
      cyc(3);
      chk("t3_ngrants", gq.size() - base, 4);
      chk("t3_order", {8'(gq[base]), 8'(gq[base+1]), 8'(gq[base+2]), 8'(gq[base+3])},
          {8'd0, 8'd3, 8'd0, 8'd3});

      // ---- T4: watchdog timeout, then next requester ----
      a1 = ack_cnt[1]; a2 = ack_cnt[2]; e1 = err_cnt[1];
      hang = 1'b1;
      req = 4'b0110;
      wait_gnt();
      chk("t4_gnt", gnt, 4'b0010);
      cycles = 0;
      while (err == '0 && ack == '0 && cycles < 200) begin @(negedge clk); cycles++; end
      chk("t4_cycles", cycles,    TIMEOUT);
      chk("t4_err",    err,       4'b0010);
      chk("t4_noack",  ack,       0);
      chk("t4_start",  eng_start, 0);
      req[1] = 1'b0;
      hang = 1'b0;
      wait_resp(1, 1);
      wait_idle();
      cyc(2);
      chk("t4_next",     gq[gq.size() - 1], 2);
      chk("t4_err_cnt",  err_cnt[1] - e1, 1);
      chk("t4_ack1_cnt", ack_cnt[1] - a1, 0);
      chk("t4_ack2_cnt", ack_cnt[2] - a2, 1);

      // ---- T5: data change and request drop mid-SHIFT (ptr=3, wraps to 0) ----
      a0 = ack_cnt[0];
      req_data[0 +: DW] = 12'h123;
      req = 4'b0001;
      wait_gnt();
      chk("t5_gnt", gnt, 4'b0001);
      wait_cs_low();
      cyc(4);
      req_data[0 +: DW] = 12'hFFF;
      req = '0;
      cyc(1);
      chk("t5_din_mid", eng_din, 12'h123);
      wait_resp(1, 0);
      chk("t5_ack",     ack,     4'b0001);
      chk("t5_din_ack", eng_din, 12'h123);
      wait_idle();
      cyc(2);
      chk("t5_ack_cnt", ack_cnt[0] - a0, 1);

      // ---- T6: reset mid-SHIFT ----
      req_data[2*DW +: DW] = 12'h456;
      req = 4'b0100;
      wait_gnt();
      wait_cs_low();
      cyc(3);
      rst_n = 1'b0;
      cyc(1);
      rst_n = 1'b1;
      chk_reset_outs("t6");
      chk("t6_eng_still_shifting", eng_cs, 0);
      viol = 0;
      t = 0;
      while (eng_cs == 1'b0 && t < 100) begin
         if (gnt != '0) viol++;
         @(negedge clk);
         t++;
      end
      chk("t6_cs_wait",  32'(t < 100), 1);
      chk("t6_no_grant", viol, 0);
      a2 = ack_cnt[2];
      wait_resp(1, 1);
      wait_idle();
      cyc(2);
      chk("t6_ack_cnt", ack_cnt[2] - a2, 1);
      chk("t6_owner",   gq[gq.size() - 1], 2);
      chk("t6_din",     dq[dq.size() - 1], 12'h456);

      // ---- global protocol properties ----
      chk("overlap",   overlap,  0);
      chk("ack_err",   both,     0);
      chk("ack_width", long_ack, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/spi_tx_arbiter.md
Name: spi_tx_arbiter

Overview:
- Round-robin arbiter that shares one 12-bit SPI transmit engine among NREQ requesters.
- Engine interface: start/din in; cs/done out, where cs is active-low and done pulses in the engine's slow-SCLK domain.
- Per requester: latches the request word, launches the engine, and tracks completion.
- Routes the engine's chip-select to the granted requester's slave-select line.
- Returns a one-cycle ack, or an error on watchdog timeout.
- Sits between multiple DAC/peripheral command sources and the single SPI transmitter.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DW, 12, SPI word width.
- TIMEOUT, 4096, max clk cycles per transfer phase before abort.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  synchronous, active-low reset.
- req  in  NREQ  level request per requester; held until ack or err.
- req_data  in  NREQ*DW  word for requester i at bits [i*DW +: DW].
- gnt  out  NREQ  one-hot; current owner of the engine.
- ack  out  NREQ  one-cycle pulse to owner on successful completion.
- err  out  NREQ  one-cycle pulse to owner on watchdog timeout.
- busy  out  1  high in any state except IDLE.
- ss_n  out  NREQ  per-slave select; ss_n[owner] = eng_cs while granted, others 1.
- eng_start  out  1  start level to engine.
- eng_din  out  DW  latched word to engine.
- eng_cs  in  1  engine chip-select (low = shifting).
- eng_done  in  1  engine done (slow-domain pulse, many clk wide).

Behaviour:
- Reset (rst_n=0 at posedge): state IDLE; gnt=0, ack=0, err=0, busy=0, eng_start=0, eng_din=0, ss_n=all 1, rr pointer=0, watchdog=0.
- eng_cs and eng_done each pass through a 2-flop synchronizer.
- A registered copy of synchronized eng_done gives a rising-edge detect done_rise.
- Priority search starts at ptr and wraps modulo NREQ; the lowest index at or after ptr wins.
- IDLE: if any req, load owner=winner and eng_din=req_data[owner]; set gnt one-hot and busy=1; go LAUNCH next cycle.
- IDLE grant latency: req high at edge N gives gnt at edge N+1.
- LAUNCH: eng_start=1, watchdog counts.
  - When synchronized eng_cs==0: eng_start=0, watchdog cleared, go SHIFT.
- SHIFT: wait for done_rise, then pulse ack[owner] for one cycle and go RELEASE.
- RELEASE:
  - Hold gnt until synchronized eng_done==0 and eng_cs==1, so a stale done is never reused.
  - Then gnt=0, ptr=(owner+1) mod NREQ, go IDLE.
  - Minimum one cycle in IDLE between grants.
- Watchdog: in LAUNCH or SHIFT, count reaching TIMEOUT-1 causes eng_start=0, err[owner] pulse, then RELEASE.
- ack and err are mutually exclusive.
- eng_din and owner are frozen from grant until leaving RELEASE; req_data changes mid-transfer are ignored.
- req deasserted mid-transfer: the transfer completes and ack is still pulsed.
- Simultaneous requests: round-robin with no starvation; worst-case wait is NREQ-1 transfers.
- Single requester held high repeatedly: served back-to-back, ptr wraps past it and returns to it.
- NREQ not a power of two: ptr wraps explicitly at NREQ-1 to 0.
- Reset mid-transfer: outputs return to reset values on the next edge.
  - ss_n goes all 1 immediately, but the engine may still be shifting.
  - After reset, IDLE waits for synchronized eng_cs==1 before granting.

Decomposition:
- Shared package spi_pkg: state encoding IDLE/LAUNCH/SHIFT/RELEASE (2 bits), default DW=12, TIMEOUT width function (clog2).
- One sub-module rr_pick: combinational rotate-priority encoder taking (req, ptr) and giving (valid, index). Reusable by later I2C/UART arbiters.
- Synchronizers stay inline.

Test Plan:
- Single request: req=0001, data0=12'hA5C.
  - Required: gnt=0001 the next cycle, eng_din=12'hA5C, eng_start high until eng_cs low, ss_n=1110 during shifting.
  - One ack[0] pulse after done_rise; gnt clears once done falls.
- All four requesting, ptr=0, words 12'h001/002/003/004.
  - Required: grant order 0,1,2,3, each acked once, eng_din sequence 001,002,003,004, no gnt overlap.
- Fairness: req=1001 held continuously.
  - Required: grants alternate 0,3,0,3 across 4 transfers, even though 0 is lower index.
- Timeout: TIMEOUT=64, engine model never drops eng_cs.
  - Required: err[owner] pulses at cycle 64 of LAUNCH, eng_start drops, no ack.
  - Next requester is then granted normally.
- Data change and request drop mid-transfer: change req_data[0] to 12'hFFF and drop req[0] during SHIFT.
  - Required: eng_din stays at the original value and ack[0] still pulses.
- Reset mid-SHIFT: rst_n=0 for 1 cycle.
  - Required: all outputs at reset values the next cycle.
  - No new grant until the engine model raises eng_cs.
  - A subsequent request completes normally.
